// File: rtl/ctr_snapshot_reader.sv
// Read port for the 64-bit cycle counter. A low-half read snapshots the full
// value so a later high-half read is coherent. Also raises a sticky compare irq.
//
// state | meaning
// IDLE  | waiting for rd_req; accepting a low read captures the snapshot
// RESP  | request in flight; response is registered on the next edge
module ctr_snapshot_reader #(
  parameter int WIDTH = 64,
  parameter int BUS   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [BUS-1:0]   rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             busy,
  input  logic             cmp_en,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             irq_clr,
  output logic             irq
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             sel_q;
  logic [WIDTH-1:0] snap;
  logic             snap_ok;
  logic             hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RESP);
    accept = (state == IDLE) && rd_req;
  end

  // Snapshot is taken at the acceptance edge; the response uses it one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q    <= 1'b0;
      snap     <= '0;
      snap_ok  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      if (accept) begin
        sel_q <= rd_sel;
        if (!rd_sel) begin
          snap    <= cnt_in;
          snap_ok <= 1'b1;
        end
      end
      if (state == RESP) begin
        rd_valid <= 1'b1;
        if (sel_q) begin
          rd_data <= snap[WIDTH-1:BUS];
          rd_err  <= ~snap_ok;
        end else begin
          rd_data <= snap[BUS-1:0];
        end
      end
    end
  end

  assign hit = cmp_en && (cnt_in == cmp_val);

  // Set dominates clear so a persisting match cannot be lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       irq <= 1'b0;
    else if (hit)     irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end

endmodule

// File: tb/tb_ctr_snapshot_reader.sv
// Directed bench for ctr_snapshot_reader: read responses go through a scoreboard
// queue checked by a monitor; irq and reset behaviour are checked inline.
module tb_ctr_snapshot_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] cnt_in;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        busy;
  logic        cmp_en;
  logic [63:0] cmp_val;
  logic        irq_clr;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  ctr_snapshot_reader #(.WIDTH(64), .BUS(32)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .busy(busy),
    .cmp_en(cmp_en), .cmp_val(cmp_val), .irq_clr(irq_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest expected response.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rd_valid: got data 0x%0h err %0b, need no response", rd_data, rd_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rd_data", 64'(rd_data), 64'(e[31:0]));
        check("rd_err", 64'(rd_err), 64'(e[32]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_read(input logic sel, input logic [31:0] exp_d, input logic exp_e);
    rd_req = 1'b1;
    rd_sel = sel;
    exp_q.push_back({exp_e, exp_d});
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_rd_err"}, 64'(rd_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_irq"}, 64'(irq), 64'd0);
  endtask

  initial begin
    reset = 1'b0; cnt_in = '0; rd_req = 1'b0; rd_sel = 1'b0;
    cmp_en = 1'b0; cmp_val = '0; irq_clr = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("post_reset");

    // High read before any low read reports an error with zero data.
    do_read(1'b1, 32'h0000_0000, 1'b1);

    // Snapshot comes from the acceptance edge even though cnt_in moves right after.
    cnt_in = 64'h0000_0001_FFFF_FFFE;
    rd_req = 1'b1; rd_sel = 1'b0;
    exp_q.push_back({1'b0, 32'hFFFF_FFFE});
    tick();
    rd_req = 1'b0;
    cnt_in = 64'h0000_0002_0000_0003;
    tick();
    do_read(1'b1, 32'h0000_0001, 1'b0);
    do_read(1'b1, 32'h0000_0001, 1'b0);
    do_read(1'b0, 32'h0000_0003, 1'b0);
    do_read(1'b1, 32'h0000_0002, 1'b0);

    // Request held into the busy cycle is dropped; exactly one response.
    cnt_in = 64'h0000_0003_1234_5678;
    rd_req = 1'b1; rd_sel = 1'b0;
    exp_q.push_back({1'b0, 32'h1234_5678});
    tick();
    check("busy_in_flight", 64'(busy), 64'd1);
    check("valid_latency_early", 64'(rd_valid), 64'd0);
    cnt_in = 64'hAAAA_BBBB_CCCC_DDDD;
    rd_sel = 1'b1;
    tick();
    rd_req = 1'b0;
    check("valid_latency_2", 64'(rd_valid), 64'd1);
    check("busy_released", 64'(busy), 64'd0);
    tick();
    check("valid_one_cycle", 64'(rd_valid), 64'd0);
    do_read(1'b1, 32'h0000_0003, 1'b0);

    // Compare while counting up through 5.
    cmp_val = 64'd5;
    for (int k = 0; k < 8; k++) begin
      cnt_in = 64'(k);
      cmp_en = 1'b1;
      tick();
      check($sformatf("irq_up_%0d", k), 64'(irq), 64'(k >= 5));
    end
    cnt_in = 64'd8; irq_clr = 1'b1;
    tick();
    check("irq_cleared", 64'(irq), 64'd0);
    irq_clr = 1'b0;

    cnt_in = 64'd5; cmp_en = 1'b0;
    tick();
    check("irq_cmp_disabled", 64'(irq), 64'd0);
    cmp_en = 1'b1;

    // Set beats simultaneous clear; clear works once the hit is gone.
    cnt_in = 64'd5; irq_clr = 1'b1;
    tick();
    check("irq_set_beats_clr", 64'(irq), 64'd1);
    cnt_in = 64'd6;
    tick();
    check("irq_clr_after_hit", 64'(irq), 64'd0);
    irq_clr = 1'b0;

    cmp_val = 64'd3;
    for (int k = 6; k >= 2; k--) begin
      cnt_in = 64'(k);
      tick();
      check($sformatf("irq_down_%0d", k), 64'(irq), 64'(k <= 3));
    end

    // Reset in the middle of a request aborts it and forgets the snapshot.
    cnt_in = 64'h0000_0005_0000_0007;
    rd_req = 1'b1; rd_sel = 1'b0;
    tick();
    rd_req = 1'b0;
    check("busy_before_abort", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    cmp_en = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_all_zero("abort_release");
    tick();
    do_read(1'b1, 32'h0000_0000, 1'b1);
    tick(); tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctr_snapshot_reader.md
# ctr_snapshot_reader

Reader-side companion to the 64-bit up/down cycle counter. It presents the live counter value to a 32-bit request/response read port. A low-half read atomically snapshots the full 64-bit value, so a following high-half read is coherent with it. It also raises a sticky compare-match interrupt when the counter equals a programmed value, and sits between the counter and the control/status bus.

## Interface
- WIDTH, 64, counter width; must equal 2*BUS.
- BUS, 32, read-data width.

- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low (asserted when 0); clears all state immediately.
- cnt_in  input  WIDTH  live counter value, sampled on clk.
- rd_req  input  1  read request, single-cycle pulse; accepted only when busy=0.
- rd_sel  input  1  0 = low half (takes a new snapshot), 1 = high half (from shadow).
- rd_data  output  BUS  read result, valid while rd_valid=1.
- rd_valid  output  1  one-cycle response strobe.
- rd_err  output  1  qualifies rd_valid: high-half read with no prior low read since reset.
- busy  output  1  high while a request is in flight; requests are ignored while high.
- cmp_en  input  1  compare enable.
- cmp_val  input  WIDTH  compare value.
- irq_clr  input  1  clears irq.
- irq  output  1  sticky compare-match interrupt.

## Operation
- FSM states: IDLE, RESP. reset forces IDLE.
- IDLE with rd_req=1 on an edge: latch rd_sel. If rd_sel=0, snap <= cnt_in and snap_ok <= 1. Go to RESP.
- RESP on the next edge:
  - rd_valid <= 1.
  - rd_data <= snap[BUS-1:0] for a low read.
  - rd_data <= snap[WIDTH-1:BUS] for a high read; rd_err <= ~snap_ok.
  - Return to IDLE.
- In every other cycle, rd_valid <= 0 and rd_err <= 0. rd_data holds its last value.
- busy = (state == RESP), combinational from state.
- A high read never re-samples cnt_in. Any number of high reads return the same shadow until the next low read.
- Compare: hit = cmp_en & (cnt_in == cmp_val), full-width equality, with no wrap or direction logic.
- On an edge, irq <= 1 if hit; else irq <= 0 if irq_clr; else irq holds. Set wins over a simultaneous clear.
- Compare runs independently of the read FSM.

## Timing
- Reset values: rd_data=0, rd_valid=0, rd_err=0, busy=0, irq=0, snap=0, snap_ok=0, state=IDLE.
- rd_req accepted at edge N. rd_valid is high for exactly the cycle after edge N+1 (latency 2 edges).
- The earliest next acceptance is edge N+2, giving a back-to-back throughput of 1 read per 2 cycles.
- rd_req asserted at edge N+1 (busy=1) is dropped, not queued.
- Snapshot is the cnt_in value present at acceptance edge N, not at N+1.
- irq asserts the cycle after the edge on which hit is sampled, with 1-cycle latency.
- A hit that persists keeps re-setting irq; irq_clr only takes effect once hit is gone.
- Reset asserted mid-request aborts it: no rd_valid is produced, and snap_ok returns to 0.
- Deasserting reset does not raise any output spuriously.

## Test plan
- Reset, then high read → rd_valid=1, rd_err=1, rd_data=0x0000_0000.
- Low read accepted with cnt_in=0x0000_0001_FFFF_FFFE, then high read after cnt_in has moved to 0x0000_0002_0000_0003 → low returns 0xFFFF_FFFE, high returns 0x0000_0001 with rd_err=0.
- rd_req on the cycle immediately after acceptance (busy=1) → ignored. Exactly one rd_valid pulse occurs, 2 edges after the first request.
- cmp_en=1, cmp_val=5, counter counting up from 0 → irq rises on the cycle after cnt_in=5 is sampled. irq stays high after cnt_in=6. irq_clr pulse clears it.
- irq_clr asserted on the same edge as a hit → irq=1. Counting down through cmp_val=3 (from 6) also triggers irq.
- reset pulled low while busy=1 → all outputs 0 immediately. No rd_valid follows, and a subsequent high read reports rd_err=1.
